// File: rtl/bcd_count2.sv
// Two-digit BCD counter with prescaler, validated load, up/down and terminal-count pulse.
// Define BCD_COUNT2_SAT_EN to saturate at the count bounds instead of wrapping.
module bcd_count2 #(
  parameter int unsigned DIV = 50000000,
  parameter int unsigned MOD = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       set,
  input  logic       up,
  input  logic [7:0] load_val,
  output logic [7:0] out,
  output logic       tick,
  output logic       tc
);
  localparam int unsigned   DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  // Upper count bound kept as BCD digits so the datapath never converts binary.
  localparam logic [3:0]    MAX_T    = 4'((MOD - 1) / 10);
  localparam logic [3:0]    MAX_O    = 4'((MOD - 1) % 10);

  logic [DW-1:0] div_cnt;
  logic [3:0]    tens, ones, nxt_t, nxt_o;
  logic          step, at_max, at_min, nxt_tc, ld_ok;

  assign step   = en && (div_cnt == DIV_LAST);
  assign at_max = (tens == MAX_T) && (ones == MAX_O);
  assign at_min = (tens == 4'd0) && (ones == 4'd0);
  assign ld_ok  = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                  ((load_val[7:4] < MAX_T) ||
                   ((load_val[7:4] == MAX_T) && (load_val[3:0] <= MAX_O)));
  assign out    = {tens, ones};

  always_comb begin
    nxt_t  = tens;
    nxt_o  = ones;
    nxt_tc = 1'b0;
    if (up) begin
      if (at_max) begin
`ifndef BCD_COUNT2_SAT_EN
        nxt_t  = 4'd0;
        nxt_o  = 4'd0;
        nxt_tc = 1'b1;
`endif
      end else begin
        if (ones == 4'd9) begin
          nxt_o = 4'd0;
          nxt_t = tens + 4'd1;
        end else begin
          nxt_o = ones + 4'd1;
        end
`ifdef BCD_COUNT2_SAT_EN
        nxt_tc = (nxt_t == MAX_T) && (nxt_o == MAX_O);
`endif
      end
    end else begin
      if (at_min) begin
`ifndef BCD_COUNT2_SAT_EN
        nxt_t  = MAX_T;
        nxt_o  = MAX_O;
        nxt_tc = 1'b1;
`endif
      end else begin
        if (ones == 4'd0) begin
          nxt_o = 4'd9;
          nxt_t = tens - 4'd1;
        end else begin
          nxt_o = ones - 4'd1;
        end
`ifdef BCD_COUNT2_SAT_EN
        nxt_tc = (nxt_t == 4'd0) && (nxt_o == 4'd0);
`endif
      end
    end
  end

  // Load beats step; an out-of-range load value collapses to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      tens    <= 4'd0;
      ones    <= 4'd0;
      tick    <= 1'b0;
      tc      <= 1'b0;
    end else if (set) begin
      div_cnt      <= '0;
      {tens, ones} <= ld_ok ? load_val : 8'h00;
      tick         <= 1'b0;
      tc           <= 1'b0;
    end else begin
      tick <= step;
      tc   <= step && nxt_tc;
      if (en) div_cnt <= step ? '0 : div_cnt + DW'(1);
      if (step) {tens, ones} <= {nxt_t, nxt_o};
    end
  end
endmodule

// File: tb/tb_bcd_count2.sv
// Bench for bcd_count2: two instances (DIV=4/MOD=100, DIV=1/MOD=60) against an integer reference model.
module tb_bcd_count2;
  logic       clk = 1'b0, rst = 1'b0, en = 1'b0, set = 1'b0, up = 1'b1;
  logic [7:0] load_val = 8'h00;
  logic [7:0] out0, out1;
  logic       tick0, tick1, tc0, tc1;
  int         total = 0, bad = 0;

  typedef struct { int val; int cnt; bit tick; bit tc; } mst_t;
  mst_t m[2] = '{'{0, 0, 1'b0, 1'b0}, '{0, 0, 1'b0, 1'b0}};

  always #5 clk = ~clk;

  bcd_count2 #(.DIV(4), .MOD(100)) u0 (.clk(clk), .rst(rst), .en(en), .set(set), .up(up),
    .load_val(load_val), .out(out0), .tick(tick0), .tc(tc0));
  bcd_count2 #(.DIV(1), .MOD(60)) u1 (.clk(clk), .rst(rst), .en(en), .set(set), .up(up),
    .load_val(load_val), .out(out1), .tick(tick1), .tc(tc1));

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Count kept as a plain integer; prescaler as an integer phase.
  function automatic mst_t mnext(mst_t s, int dv, int md, logic st, logic e, logic u, logic [7:0] lv);
    int   lt = int'(lv[7:4]);
    int   lo = int'(lv[3:0]);
    mst_t n  = s;
    n.tick = 1'b0;
    n.tc   = 1'b0;
    if (st) begin
      n.cnt = 0;
      n.val = (lt <= 9 && lo <= 9 && lt * 10 + lo < md) ? lt * 10 + lo : 0;
    end else if (e) begin
      if (s.cnt == dv - 1) begin
        n.cnt  = 0;
        n.tick = 1'b1;
`ifdef BCD_COUNT2_SAT_EN
        if (u && s.val < md - 1) begin
          n.val = s.val + 1; n.tc = (n.val == md - 1);
        end else if (!u && s.val > 0) begin
          n.val = s.val - 1; n.tc = (n.val == 0);
        end
`else
        if (u) begin
          n.val = (s.val + 1) % md; n.tc = (n.val == 0);
        end else begin
          n.val = (s.val + md - 1) % md; n.tc = (s.val == 0);
        end
`endif
      end else begin
        n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) m[i] <= '{0, 0, 1'b0, 1'b0};
    end else begin
      m[0] <= mnext(m[0], 4, 100, set, en, up, load_val);
      m[1] <= mnext(m[1], 1, 60, set, en, up, load_val);
    end
  end

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; up = 1'b1; set = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({out0, tick0, tc0, out1, tick1, tc1} !== 20'h0) begin
      bad++; $display("FAIL reset_state got out0=%h out1=%h tick=%b%b tc=%b%b want 00/00/0/0", out0, out1, tick0, tick1, tc0, tc1);
    end
    rst = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      total++;
      if (tick0 !== (c == 4)) begin bad++; $display("FAIL reset_first_tick c=%0d got %b want %b", c, tick0, (c == 4)); end
      if (c == 4) begin
        total++;
        if (out0 !== 8'h01) begin bad++; $display("FAIL reset_first_out got %h want 01", out0); end
      end
      total++;
      if ({out1, tick1, tc1} !== {bcd(m[1].val), m[1].tick, m[1].tc}) begin
        bad++; $display("FAIL reset_model_u1 got %h/%b/%b want %h/%b/%b", out1, tick1, tc1, bcd(m[1].val), m[1].tick, m[1].tc);
      end
    end
  endtask

  task automatic test_up_wrap();
    set = 1'b1; load_val = 8'h98; up = 1'b1;
    @(negedge clk);
    set = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      total++;
      if ({out0, tick0, tc0} !== {bcd(m[0].val), m[0].tick, m[0].tc}) begin
        bad++; $display("FAIL upwrap_model c=%0d got %h/%b/%b want %h/%b/%b", c, out0, tick0, tc0, bcd(m[0].val), m[0].tick, m[0].tc);
      end
      if (c % 4 == 0) begin
        total++;
        if ({out0, tick0, tc0} !== {(c == 4) ? 8'h99 : (c == 8) ? 8'h00 : 8'h01, 1'b1, c == 8}) begin
          bad++; $display("FAIL upwrap_step c=%0d got out=%h tick=%b tc=%b", c, out0, tick0, tc0);
        end
      end
    end
  endtask

  task automatic test_down_wrap();
    set = 1'b1; load_val = 8'h00; up = 1'b0;
    @(negedge clk);
    set = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++;
      if ({out1, tick1, tc1} !== {(c == 1) ? 8'h59 : (c == 2) ? 8'h58 : 8'h57, 1'b1, c == 1}) begin
        bad++; $display("FAIL downwrap_mod60 c=%0d got out=%h tick=%b tc=%b", c, out1, tick1, tc1);
      end
      total++;
      if ({out0, tick0, tc0} !== {bcd(m[0].val), m[0].tick, m[0].tc}) begin
        bad++; $display("FAIL downwrap_model_u0 got %h/%b/%b want %h/%b/%b", out0, tick0, tc0, bcd(m[0].val), m[0].tick, m[0].tc);
      end
    end
  endtask

  task automatic test_load();
    logic [7:0] lv[3]  = '{8'h5A, 8'h75, 8'h42};
    logic [7:0] ex0[3] = '{8'h00, 8'h75, 8'h42};
    logic [7:0] ex1[3] = '{8'h00, 8'h00, 8'h42};
    up = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set = 1'b1; load_val = lv[k];
      @(negedge clk);
      set = 1'b0;
      total++;
      if ({out0, out1, tick0, tc0} !== {ex0[k], ex1[k], 2'b00}) begin
        bad++; $display("FAIL load_%h got %h/%h tick=%b tc=%b want %h/%h 0/0", lv[k], out0, out1, tick0, tc0, ex0[k], ex1[k]);
      end
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        total++;
        if ({out0, tick0} !== {(c == 4) ? bcd(int'(ex0[k][7:4]) * 10 + int'(ex0[k][3:0]) + 1) : ex0[k], c == 4}) begin
          bad++; $display("FAIL load_prescale_%h c=%0d got out=%h tick=%b", lv[k], c, out0, tick0);
        end
      end
    end
  endtask

  task automatic test_collision_freeze();
    up = 1'b1; en = 1'b1;
    set = 1'b1; load_val = 8'h42;
    @(negedge clk);
    set = 1'b0;
    repeat (3) @(negedge clk);
    set = 1'b1; load_val = 8'h17;
    @(negedge clk);
    set = 1'b0;
    total++;
    if ({out0, tick0, tc0} !== {8'h17, 2'b00}) begin
      bad++; $display("FAIL collision got out=%h tick=%b tc=%b want 17/0/0", out0, tick0, tc0);
    end
    repeat (2) @(negedge clk);
    en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      total++;
      if ({out0, tick0, out1, tick1} !== {8'h17, 1'b0, bcd(m[1].val), 1'b0}) begin
        bad++; $display("FAIL freeze c=%0d got %h/%b %h/%b want 17/0 %h/0", c, out0, tick0, out1, tick1, bcd(m[1].val));
      end
    end
    en = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      total++;
      if ({out0, tick0} !== {(c == 2) ? 8'h18 : 8'h17, c == 2}) begin
        bad++; $display("FAIL resume c=%0d got out=%h tick=%b", c, out0, tick0);
      end
    end
  endtask

  task automatic test_async_reset();
    set = 1'b1; load_val = 8'h30; up = 1'b1; en = 1'b1;
    @(negedge clk);
    set = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({out0, tick0, tc0, out1, tick1, tc1} !== 20'h0) begin
      bad++; $display("FAIL async_reset got %h/%b/%b %h/%b/%b want all zero", out0, tick0, tc0, out1, tick1, tc1);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      total++;
      if ({out0, tick0} !== {(c == 4) ? 8'h01 : 8'h00, c == 4}) begin
        bad++; $display("FAIL async_release c=%0d got out=%h tick=%b", c, out0, tick0);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      total++;
      if ({out0, tick0, tc0} !== {bcd(m[0].val), m[0].tick, m[0].tc}) begin
        bad++; $display("FAIL rand_u0 c=%0d got %h/%b/%b want %h/%b/%b", c, out0, tick0, tc0, bcd(m[0].val), m[0].tick, m[0].tc);
      end
      total++;
      if ({out1, tick1, tc1} !== {bcd(m[1].val), m[1].tick, m[1].tc}) begin
        bad++; $display("FAIL rand_u1 c=%0d got %h/%b/%b want %h/%b/%b", c, out1, tick1, tc1, bcd(m[1].val), m[1].tick, m[1].tc);
      end
      en  = ($urandom_range(0, 9) != 0);
      set = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 15) == 0) up = ~up;
      load_val = $urandom_range(0, 1) ? 8'($urandom) : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    end
    set = 1'b0; en = 1'b1;
  endtask

`ifdef BCD_COUNT2_SAT_EN
  task automatic test_saturation();
    set = 1'b1; load_val = 8'h97; up = 1'b1; en = 1'b1;
    @(negedge clk);
    set = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c % 4 == 0) begin
        total++;
        if ({out0, tick0, tc0} !== {(c == 4) ? 8'h98 : 8'h99, 1'b1, c == 8}) begin
          bad++; $display("FAIL saturate c=%0d got out=%h tick=%b tc=%b", c, out0, tick0, tc0);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_collision_freeze();
    test_async_reset();
    test_random();
`ifdef BCD_COUNT2_SAT_EN
    test_saturation();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_count2.md
# bcd_count2

Two-digit BCD counter with a built-in prescaler, loadable value, up/down direction and a terminal-count pulse. It sits directly upstream of the dual seven-segment display stage. Its 8-bit `out` bus (`{tens, ones}`) connects straight to that stage's 8-bit `in`. It shares `clk`, `set` and `en` with the display stage, so a single control bundle drives both.

## Interface
- `DIV`, default 50000000: clocks per count step; legal range 1..2^26.
- `MOD`, default 100: count modulus in decimal; legal range 2..100; the count range is 0..MOD-1.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: count enable; when low, the prescaler and the count freeze.
- `set` in 1: synchronous load strobe.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `load_val` in 8: BCD value to load, `{tens[7:4], ones[3:0]}`.
- `out` out 8: current BCD count, `{tens, ones}`; registered.
- `tick` out 1: one-cycle pulse on every count step; registered.
- `tc` out 1: one-cycle pulse on every wrap (or on reaching a bound, see Configuration); registered.

## Operation
- **Reset** (`rst`=0, asynchronous): `out`=8'h00, `tick`=0, `tc`=0, prescaler `div_cnt`=0.
- **Prescaler**
  - While `en`=1, `div_cnt` counts 0..DIV-1.
  - At DIV-1, a *step* occurs and `div_cnt` returns to 0.
  - While `en`=0, `div_cnt` holds.
  - With DIV=1, every enabled cycle is a step.
- **Priority per edge:** `set` > step > hold.
- **Load** (`set`=1):
  - Acts regardless of `en`.
  - Clears `div_cnt`; `tick`=0, `tc`=0.
  - `load_val` is valid only if both nibbles are ≤9 and the decimal value is < MOD.
  - A valid value loads into `out`; an invalid value loads 8'h00.
- **Step, `up`=1:**
  - Ones 0..8 → +1.
  - Ones 9 → ones=0 and tens+1.
  - At MOD-1 → 8'h00, with `tc`=1.
- **Step, `up`=0:**
  - Ones 1..9 → -1.
  - Ones 0 → ones=9 and tens-1.
  - At 00 → BCD of MOD-1, with `tc`=1.
- **`tick`** is 1 for exactly the cycle following each step edge; otherwise 0.
- **`tc`** is 1 only on wrap steps, for one cycle; otherwise 0.
- **`up` changes** are sampled only at the step edge; no other effect.
- **Internal arithmetic:** tens and ones are held as separate 4-bit BCD digits. No binary-to-BCD conversion occurs in the datapath. The MOD-1 bound is precomputed as a BCD constant.

## Timing
- **Load latency:** `set` high at edge k → `out` shows the loaded value after edge k.
- **Step edge:** `out`, `tick` and `tc` all update on the same edge. `out` is already the new value while `tick`/`tc` are high.
- **Step spacing:** with `en` continuously high, steps are exactly DIV cycles apart. The first step after reset or load occurs DIV cycles after the releasing edge.
- **`set` coinciding with a step edge:** the load wins, no step is taken, `tick`=0, `tc`=0.
- **`en` dropping mid-interval:** remaining cycles resume from the held `div_cnt` when `en` returns.
- **Reset mid-interval:** all outputs clear immediately, with no clock needed. The first step comes DIV cycles after `rst` deasserts.
- **Outputs:** all are glitch-free register outputs; there is no combinational path from any input to any output.

## Configuration
- **Macro:** `BCD_COUNT2_SAT_EN`.
- **Defined:** the count saturates instead of wrapping.
  - Up at MOD-1 holds MOD-1; down at 00 holds 00.
  - `tc` pulses once on the step that first reaches the bound, not on held steps.
  - `tick` still pulses every step.
- **Undefined (default):** wrap-around behaviour as in Operation.

## Test plan
- **Reset:** hold `rst`=0, then release; DIV=4, MOD=100, `en`=1, `up`=1 → `out`=00 during reset. `tick` first pulses 4 cycles after release, with `out`=01.
- **Up wrap:** load 8'h98, count up, DIV=4 → `out` 98→99→00. `tc`=1 only with 00; `tick` pulses every 4 cycles.
- **Down wrap, reduced modulus:** MOD=60, load 8'h00, `up`=0, DIV=1 → `out`=59 with `tc`=1, then 58, 57.
- **Invalid load and clean load:**
  - `load_val`=8'h5A → `out`=00.
  - `load_val`=8'h75 with MOD=60 → `out`=00.
  - `load_val`=8'h42 → `out`=42, with `div_cnt` cleared.
- **Load/step collision and freeze:**
  - `set` asserted on the step edge → loaded value appears, no `tick`.
  - `en`=0 for 10 cycles mid-interval → `out` frozen, and interval completion is deferred by exactly 10 cycles.
- **Saturation** (with `BCD_COUNT2_SAT_EN`): load 8'h97, count up → 98, 99 (`tc`=1), then 99 with `tc`=0 while `tick` keeps pulsing.
